// File: rtl/tlb_port_arbiter_pkg.sv
// Shared types and requester IDs for the TLB lookup-port arbiter.
// Grant vectors are indexed by REQ_* so the fetch/memory/CP0 views agree.
package tlb_port_arbiter_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_BLOCK = 1'b1
    } arb_state_t;

    localparam int REQ_INST  = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_PROBE = 2;
    localparam int NUM_REQ   = 3;

endpackage

// File: rtl/tlb_arb_prio.sv
// Combinational picker for the TLB lookup port: probe first, then data over
// inst unless fetch has been starved long enough to take precedence.
module tlb_arb_prio
    import tlb_port_arbiter_pkg::*;
(
    input  logic               i_en,
    input  logic               i_inst_req,
    input  logic               i_data_req,
    input  logic               i_probe_req,
    input  logic               i_starved,
    output logic [NUM_REQ-1:0] o_gnt
);

    always_comb begin
        o_gnt = '0;
        if (i_en) begin
            if (i_probe_req)
                o_gnt[REQ_PROBE] = 1'b1;
            else if (i_inst_req && (i_starved || !i_data_req))
                o_gnt[REQ_INST] = 1'b1;
            else if (i_data_req)
                o_gnt[REQ_DATA] = 1'b1;
        end
    end

endmodule

// File: rtl/tlb_port_arbiter.sv
// Shares the single TLB lookup port between fetch, load/store and TLBP probe,
// with a write blackout window and a fetch anti-starvation override.
//
// state    | meaning
// ST_RUN   | lookups may be granted
// ST_BLOCK | post-tlb_write blackout, r_blk_cnt counts down, no grants
module tlb_port_arbiter
    import tlb_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int WR_BLACKOUT  = 1,
    parameter int IDX_W        = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_req,
    input  logic [31:0]      i_vaddr,
    output logic             i_gnt,
    output logic             i_rvalid,
    input  logic             d_req,
    input  logic [31:0]      d_vaddr,
    output logic             d_gnt,
    output logic             d_rvalid,
    input  logic             p_req,
    input  logic [31:0]      p_vaddr,
    output logic             p_gnt,
    output logic             p_rvalid,
    output logic [31:0]      r_paddr,
    output logic             r_miss,
    output logic             r_invalid,
    output logic             r_dirty,
    output logic [2:0]       r_cattr,
    output logic [IDX_W-1:0] r_index,
    output logic [31:0]      tlb_vaddr,
    input  logic [31:0]      tlb_paddr,
    input  logic             tlb_miss,
    input  logic             tlb_invalid,
    input  logic             tlb_dirty,
    input  logic [2:0]       tlb_cattr,
    input  logic [IDX_W-1:0] tlb_index,
    input  logic             tlb_write,
    input  logic             flush,
    output logic [31:0]      perfcnt_conflict
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(WR_BLACKOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BLK_LOAD   = BW'(WR_BLACKOUT);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [BW-1:0]        r_blk_cnt;
    logic [SW-1:0]        r_starve_cnt;
    logic                 w_grant_en;
    logic                 w_starved;
    logic                 w_any_gnt;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [NUM_REQ-1:0]   r_rvalid;
    logic [1:0]           w_req_cnt;

    always_ff @(posedge clk) begin
        if (!resetn)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (tlb_write) w_state_nxt = ST_BLOCK;
            ST_BLOCK: if (r_blk_cnt == BW'(1) && !tlb_write) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // A write in the current cycle also blocks, since the array is mid-update.
    always_comb begin
        w_grant_en = resetn && (r_state == ST_RUN) && !tlb_write;
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            r_blk_cnt <= '0;
        else if (tlb_write)
            r_blk_cnt <= BLK_LOAD;
        else if (r_state == ST_BLOCK && r_blk_cnt != '0)
            r_blk_cnt <= r_blk_cnt - BW'(1);
    end

    assign w_starved = (r_starve_cnt == STARVE_MAX);

    tlb_arb_prio u_prio (
        .i_en        (w_grant_en),
        .i_inst_req  (i_req && !flush),
        .i_data_req  (d_req),
        .i_probe_req (p_req),
        .i_starved   (w_starved),
        .o_gnt       (w_gnt)
    );

    assign i_gnt     = w_gnt[REQ_INST];
    assign d_gnt     = w_gnt[REQ_DATA];
    assign p_gnt     = w_gnt[REQ_PROBE];
    assign w_any_gnt = |w_gnt;

    always_comb begin
        tlb_vaddr = i_vaddr;
        if (w_gnt[REQ_PROBE])
            tlb_vaddr = p_vaddr;
        else if (w_gnt[REQ_DATA])
            tlb_vaddr = d_vaddr;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            if (i_req && !flush && !w_gnt[REQ_INST]) begin
                if (r_starve_cnt != STARVE_MAX)
                    r_starve_cnt <= r_starve_cnt + SW'(1);
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

    // Result registers hold between grants; rvalid is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rvalid  <= '0;
            r_paddr   <= '0;
            r_miss    <= 1'b0;
            r_invalid <= 1'b0;
            r_dirty   <= 1'b0;
            r_cattr   <= '0;
            r_index   <= '0;
        end else if (w_any_gnt) begin
            r_rvalid  <= w_gnt;
            r_paddr   <= tlb_paddr;
            r_miss    <= tlb_miss;
            r_invalid <= tlb_invalid;
            r_dirty   <= tlb_dirty;
            r_cattr   <= tlb_cattr;
            r_index   <= tlb_index;
        end else begin
            r_rvalid  <= '0;
        end
    end

    assign i_rvalid = r_rvalid[REQ_INST];
    assign d_rvalid = r_rvalid[REQ_DATA];
    assign p_rvalid = r_rvalid[REQ_PROBE];

    assign w_req_cnt = {1'b0, i_req} + {1'b0, d_req} + {1'b0, p_req};

    always_ff @(posedge clk) begin
        if (!resetn)
            perfcnt_conflict <= '0;
        else if (w_req_cnt >= 2'd2)
            perfcnt_conflict <= perfcnt_conflict + 32'd1;
    end

endmodule

// File: tb/tb_tlb_port_arbiter.sv
// Self-checking bench for tlb_port_arbiter: directed scenarios plus a random
// run checked against a cycle-level reference model of the arbitration rules.
module tb_tlb_port_arbiter;

    localparam int STARVE_LIMIT = 8;
    localparam int WR_BLACKOUT  = 1;
    localparam int IDX_W        = 5;

    logic             clk;
    logic             resetn;
    logic             i_req, d_req, p_req;
    logic [31:0]      i_vaddr, d_vaddr, p_vaddr;
    logic             i_gnt, d_gnt, p_gnt;
    logic             i_rvalid, d_rvalid, p_rvalid;
    logic [31:0]      r_paddr;
    logic             r_miss, r_invalid, r_dirty;
    logic [2:0]       r_cattr;
    logic [IDX_W-1:0] r_index;
    logic [31:0]      tlb_vaddr;
    logic [31:0]      tlb_paddr;
    logic             tlb_miss, tlb_invalid, tlb_dirty;
    logic [2:0]       tlb_cattr;
    logic [IDX_W-1:0] tlb_index;
    logic             tlb_write;
    logic             flush;
    logic [31:0]      perfcnt_conflict;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: remaining blackout cycles, denied-fetch streak,
    // conflict count and the last captured result.
    int               m_blk;
    int               m_starve;
    logic [31:0]      m_perf;
    logic [2:0]       m_rv;
    logic [31:0]      m_paddr;
    logic [3:0]       m_flags;
    logic [2:0]       m_cattr;
    logic [IDX_W-1:0] m_index;

    tlb_port_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .WR_BLACKOUT  (WR_BLACKOUT),
        .IDX_W        (IDX_W)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .i_req            (i_req),
        .i_vaddr          (i_vaddr),
        .i_gnt            (i_gnt),
        .i_rvalid         (i_rvalid),
        .d_req            (d_req),
        .d_vaddr          (d_vaddr),
        .d_gnt            (d_gnt),
        .d_rvalid         (d_rvalid),
        .p_req            (p_req),
        .p_vaddr          (p_vaddr),
        .p_gnt            (p_gnt),
        .p_rvalid         (p_rvalid),
        .r_paddr          (r_paddr),
        .r_miss           (r_miss),
        .r_invalid        (r_invalid),
        .r_dirty          (r_dirty),
        .r_cattr          (r_cattr),
        .r_index          (r_index),
        .tlb_vaddr        (tlb_vaddr),
        .tlb_paddr        (tlb_paddr),
        .tlb_miss         (tlb_miss),
        .tlb_invalid      (tlb_invalid),
        .tlb_dirty        (tlb_dirty),
        .tlb_cattr        (tlb_cattr),
        .tlb_index        (tlb_index),
        .tlb_write        (tlb_write),
        .flush            (flush),
        .perfcnt_conflict (perfcnt_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected grant vector {p,d,i} for the inputs currently applied.
    function automatic logic [2:0] exp_gnt();
        logic inst_ok;
        inst_ok = i_req && !flush;
        if (!resetn || m_blk > 0 || tlb_write) return 3'b000;
        if (p_req) return 3'b100;
        if (inst_ok && d_req) return (m_starve == STARVE_LIMIT) ? 3'b001 : 3'b010;
        if (d_req) return 3'b010;
        if (inst_ok) return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic [31:0] exp_vaddr(input logic [2:0] g);
        if (g[2]) return p_vaddr;
        if (g[1]) return d_vaddr;
        return i_vaddr;
    endfunction

    task automatic model_update();
        logic [2:0] g;
        int nreq;
        g = exp_gnt();
        if (!resetn) begin
            m_blk = 0; m_starve = 0; m_perf = 0; m_rv = 0;
            m_paddr = 0; m_flags = 0; m_cattr = 0; m_index = 0;
            return;
        end
        if (g != 3'b000) begin
            m_rv    = g;
            m_paddr = tlb_paddr;
            m_flags = {1'b0, tlb_miss, tlb_invalid, tlb_dirty};
            m_cattr = tlb_cattr;
            m_index = tlb_index;
        end else begin
            m_rv = 3'b000;
        end
        nreq = int'(i_req) + int'(d_req) + int'(p_req);
        if (nreq >= 2) m_perf = m_perf + 32'd1;
        if (m_blk == 0) begin
            if (i_req && !flush && !g[0])
                m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
            else
                m_starve = 0;
        end
        if (tlb_write) m_blk = WR_BLACKOUT;
        else if (m_blk > 0) m_blk = m_blk - 1;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_req = 0; d_req = 0; p_req = 0; tlb_write = 0; flush = 0;
        i_vaddr = 32'h0000_1000; d_vaddr = 32'h0000_2000; p_vaddr = 32'h0000_6000;
        tlb_paddr = 0; tlb_miss = 0; tlb_invalid = 0; tlb_dirty = 0;
        tlb_cattr = 0; tlb_index = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0; i_req = 1; d_req = 1;
        #1;
        n_cmp++;
        if ({p_gnt, d_gnt, i_gnt} !== 3'b000) begin
            n_bad++; $display("FAIL reset_gnt got %b want 000", {p_gnt, d_gnt, i_gnt});
        end
        cycle(); cycle();
        #1;
        n_cmp++;
        if ({p_rvalid, d_rvalid, i_rvalid} !== 3'b000 || r_paddr !== 32'd0 || r_index !== '0) begin
            n_bad++; $display("FAIL reset_regs got rv=%b pa=%h idx=%h want 0", {p_rvalid, d_rvalid, i_rvalid}, r_paddr, r_index);
        end
        n_cmp++;
        if (perfcnt_conflict !== 32'd0) begin
            n_bad++; $display("FAIL reset_perf got %0d want 0", perfcnt_conflict);
        end
        resetn = 1;
        idle_inputs();
        cycle();
    endtask

    task automatic test_solo_inst();
        idle_inputs();
        i_req = 1; i_vaddr = 32'h0040_1000;
        tlb_paddr = 32'h1FC0_1000; tlb_cattr = 3'd3;
        #1;
        n_cmp++;
        if ({p_gnt, d_gnt, i_gnt} !== 3'b001 || tlb_vaddr !== 32'h0040_1000) begin
            n_bad++; $display("FAIL solo_gnt got gnt=%b va=%h want 001/00401000", {p_gnt, d_gnt, i_gnt}, tlb_vaddr);
        end
        cycle();
        idle_inputs();
        #1;
        n_cmp++;
        if ({p_rvalid, d_rvalid, i_rvalid} !== 3'b001) begin
            n_bad++; $display("FAIL solo_rvalid got %b want 001", {p_rvalid, d_rvalid, i_rvalid});
        end
        n_cmp++;
        if (r_paddr !== 32'h1FC0_1000 || r_cattr !== 3'd3) begin
            n_bad++; $display("FAIL solo_result got pa=%h ca=%0d want 1fc01000/3", r_paddr, r_cattr);
        end
        cycle();
        #1;
        n_cmp++;
        if ({p_rvalid, d_rvalid, i_rvalid} !== 3'b000 || r_paddr !== 32'h1FC0_1000) begin
            n_bad++; $display("FAIL solo_hold got rv=%b pa=%h want 000/1fc01000", {p_rvalid, d_rvalid, i_rvalid}, r_paddr);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] perf0;
        idle_inputs();
        #1;
        perf0 = m_perf;
        i_req = 1; d_req = 1; p_req = 1;
        #1;
        n_cmp++;
        if ({p_gnt, d_gnt, i_gnt} !== 3'b100 || tlb_vaddr !== p_vaddr) begin
            n_bad++; $display("FAIL conflict3_gnt got gnt=%b va=%h want 100/%h", {p_gnt, d_gnt, i_gnt}, tlb_vaddr, p_vaddr);
        end
        cycle();
        p_req = 0;
        #1;
        n_cmp++;
        if ({p_gnt, d_gnt, i_gnt} !== 3'b010 || tlb_vaddr !== d_vaddr) begin
            n_bad++; $display("FAIL conflict2_gnt got gnt=%b va=%h want 010/%h", {p_gnt, d_gnt, i_gnt}, tlb_vaddr, d_vaddr);
        end
        n_cmp++;
        if (perfcnt_conflict !== perf0 + 32'd1 || p_rvalid !== 1'b1) begin
            n_bad++; $display("FAIL conflict_perf got perf=%0d prv=%b want %0d/1", perfcnt_conflict, p_rvalid, perf0 + 32'd1);
        end
        cycle();
        idle_inputs();
        cycle();
    endtask

    task automatic test_starvation();
        idle_inputs();
        cycle();
        i_req = 1; d_req = 1;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_cmp++;
            if (i_gnt !== (k == 8) || d_gnt !== (k != 8)) begin
                n_bad++; $display("FAIL starve_c%0d got i=%b d=%b want i=%b d=%b", k, i_gnt, d_gnt, k == 8, k != 8);
            end
            cycle();
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_tlb_write();
        idle_inputs();
        i_req = 1; tlb_write = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (i_gnt !== (k == 2)) begin
                n_bad++; $display("FAIL wr1_T%0d got i_gnt=%b want %b", k, i_gnt, k == 2);
            end
            cycle();
            tlb_write = 0;
        end
        i_req = 0;
        cycle();
        i_req = 1; tlb_write = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (i_gnt !== (k == 3)) begin
                n_bad++; $display("FAIL wr2_T%0d got i_gnt=%b want %b", k, i_gnt, k == 3);
            end
            cycle();
            tlb_write = (k == 0);
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_flush();
        idle_inputs();
        i_req = 1; d_req = 1; flush = 1;
        #1;
        n_cmp++;
        if (i_gnt !== 1'b0 || d_gnt !== 1'b1) begin
            n_bad++; $display("FAIL flush_gnt got i=%b d=%b want 0/1", i_gnt, d_gnt);
        end
        cycle();
        flush = 0; d_req = 0;
        #1;
        n_cmp++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b1 || i_gnt !== 1'b1) begin
            n_bad++; $display("FAIL flush_after got irv=%b drv=%b ig=%b want 0/1/1", i_rvalid, d_rvalid, i_gnt);
        end
        cycle();
        flush = 1;
        #1;
        n_cmp++;
        if (i_rvalid !== 1'b1 || i_gnt !== 1'b0) begin
            n_bad++; $display("FAIL flush_rvalid got irv=%b ig=%b want 1/0", i_rvalid, i_gnt);
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        i_req = 1; tlb_paddr = 32'hABCD_0000;
        cycle();
        resetn = 0;
        #1;
        n_cmp++;
        if (i_gnt !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_gnt got %b want 0", i_gnt);
        end
        cycle();
        #1;
        n_cmp++;
        if (i_rvalid !== 1'b0 || r_paddr !== 32'd0 || perfcnt_conflict !== 32'd0) begin
            n_bad++; $display("FAIL rstmid_regs got irv=%b pa=%h perf=%0d want 0", i_rvalid, r_paddr, perfcnt_conflict);
        end
        resetn = 1;
        #1;
        n_cmp++;
        if (i_gnt !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_run got i_gnt=%b want 1", i_gnt);
        end
        cycle();
        idle_inputs();
        cycle();
    endtask

    task automatic test_random();
        logic [2:0] g;
        for (int n = 0; n < 600; n++) begin
            resetn      = ($urandom_range(63) != 0);
            i_req       = ($urandom_range(3) != 0);
            d_req       = ($urandom_range(3) != 0);
            p_req       = ($urandom_range(7) == 0);
            tlb_write   = ($urandom_range(11) == 0);
            flush       = ($urandom_range(9) == 0);
            i_vaddr     = $urandom;
            d_vaddr     = $urandom;
            p_vaddr     = $urandom;
            tlb_paddr   = $urandom;
            tlb_miss    = $urandom_range(1);
            tlb_invalid = $urandom_range(1);
            tlb_dirty   = $urandom_range(1);
            tlb_cattr   = 3'($urandom_range(7));
            tlb_index   = IDX_W'($urandom_range(31));
            #1;
            g = exp_gnt();
            n_cmp++;
            if ({p_gnt, d_gnt, i_gnt} !== g || tlb_vaddr !== exp_vaddr(g)) begin
                n_bad++; $display("FAIL rnd%0d_gnt got %b/%h want %b/%h", n, {p_gnt, d_gnt, i_gnt}, tlb_vaddr, g, exp_vaddr(g));
            end
            n_cmp++;
            if ({p_rvalid, d_rvalid, i_rvalid} !== m_rv || r_paddr !== m_paddr ||
                {1'b0, r_miss, r_invalid, r_dirty} !== m_flags || r_cattr !== m_cattr || r_index !== m_index) begin
                n_bad++; $display("FAIL rnd%0d_resp got rv=%b pa=%h ca=%0d idx=%0d want rv=%b pa=%h ca=%0d idx=%0d",
                    n, {p_rvalid, d_rvalid, i_rvalid}, r_paddr, r_cattr, r_index, m_rv, m_paddr, m_cattr, m_index);
            end
            n_cmp++;
            if (perfcnt_conflict !== m_perf) begin
                n_bad++; $display("FAIL rnd%0d_perf got %0d want %0d", n, perfcnt_conflict, m_perf);
            end
            cycle();
        end
        resetn = 1;
        idle_inputs();
        cycle();
    endtask

    initial begin
        resetn = 0;
        idle_inputs();
        m_blk = 0; m_starve = 0; m_perf = 0; m_rv = 0;
        m_paddr = 0; m_flags = 0; m_cattr = 0; m_index = 0;
        @(negedge clk);
        test_reset();
        test_solo_inst();
        test_conflict();
        test_starvation();
        test_tlb_write();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
